// File: rtl/jh_pkg.sv
// jh_pkg: shared widths, pad byte, F8 latency and padder FSM states
package jh_pkg;
  localparam int BLOCK_W = 512;
  localparam int LEN_W = 128;
  localparam int WORD_W = 64;
  localparam int F8_LATENCY = 36;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  typedef enum logic [2:0] {IDLE, INIT, FILL, SEND, WAIT} state_t;
endpackage

// File: rtl/jh_word_pad.sv
// jh_word_pad: keeps the first bytes of a word, inserts 0x80 after them and zeroes the rest
module jh_word_pad
  import jh_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [3:0]        bytes,
  output logic [WORD_W-1:0] padded
);
  logic              full;
  logic [WORD_W-1:0] mask;
  always_comb begin
    full = bytes >= 4'd8;
    mask = full ? '1 : ~({WORD_W{1'b1}} >> {bytes, 3'b000});
    padded = (word & mask) | (full ? '0 : {PAD_BYTE, {(WORD_W-8){1'b0}}} >> {bytes, 3'b000});
  end
endmodule

// File: rtl/jh_padder.sv
// jh_padder: packs a byte stream into JH-padded 512-bit blocks and drives the F8 stage
module jh_padder
  import jh_pkg::*;
#(
  parameter int DIGEST_BITS = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  input  logic [3:0]             s_bytes,
  output logic                   s_ready,
  output logic                   f8_init,
  output logic                   f8_enable,
  output logic [BLOCK_W-1:0]     f8_buffer,
  input  logic                   f8_done,
  input  logic [1023:0]          f8_state_h,
  output logic [DIGEST_BITS-1:0] digest,
  output logic                   digest_valid
);
  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [LEN_W-1:0]       len_q, len_d, len_add;
  logic [BLOCK_W-1:0]     buf_q, buf_d;
  logic                   padded_q, padded_d;
  logic                   final_pending_q, final_pending_d;
  logic                   is_final_q, is_final_d;
  logic                   wait_first_q, wait_first_d;
  logic [DIGEST_BITS-1:0] digest_q, digest_d;
  logic                   digest_valid_q, digest_valid_d;
  logic [WORD_W-1:0]      data_w, mark_w;
  logic                   unused_state_h;
  jh_word_pad u_data (.word(s_data), .bytes(s_bytes), .padded(data_w));
  jh_word_pad u_mark (.word('0), .bytes(4'd0), .padded(mark_w));
  assign unused_state_h = ^f8_state_h[1023:DIGEST_BITS];
  assign len_add = len_q + LEN_W'({s_bytes, 3'b000});
  assign f8_buffer = buf_q;
  assign digest = digest_q;
  assign digest_valid = digest_valid_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    buf_d = buf_q;
    padded_d = padded_q;
    final_pending_d = final_pending_q;
    is_final_d = is_final_q;
    wait_first_d = 1'b0;
    digest_d = digest_q;
    digest_valid_d = 1'b0;
    s_ready = 1'b0;
    f8_init = 1'b0;
    f8_enable = 1'b0;
    case (state_q)
      IDLE: state_d = s_valid ? INIT : IDLE;
      INIT: begin
        f8_init = 1'b1;
        idx_d = '0;
        len_d = '0;
        buf_d = '0;
        padded_d = 1'b0;
        final_pending_d = 1'b0;
        is_final_d = 1'b0;
        state_d = FILL;
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          len_d = len_add;
          if (!s_last) begin
            buf_d[BLOCK_W-1-WORD_W*int'(idx_q) -: WORD_W] = s_data;
            idx_d = idx_q + 3'd1;
            state_d = idx_q == 3'd7 ? SEND : FILL;
          end else if (s_bytes == 4'd0 && idx_q == 3'd0) begin
            buf_d = {PAD_BYTE, {(BLOCK_W-LEN_W-8){1'b0}}, len_add};
            padded_d = 1'b0;
            final_pending_d = 1'b0;
            is_final_d = 1'b1;
            state_d = SEND;
          end else begin
            buf_d[BLOCK_W-1-WORD_W*int'(idx_q) -: WORD_W] = data_w;
            if (s_bytes >= 4'd8 && idx_q != 3'd7)
              buf_d[BLOCK_W-1-WORD_W*(int'(idx_q)+1) -: WORD_W] = mark_w;
            padded_d = s_bytes < 4'd8 || idx_q != 3'd7;
            final_pending_d = 1'b1;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        f8_enable = f8_done;
        wait_first_d = f8_done;
        state_d = f8_done ? WAIT : SEND;
      end
      WAIT: begin
        if (!wait_first_q && f8_done) begin
          if (is_final_q) begin
            digest_d = f8_state_h[DIGEST_BITS-1:0];
            digest_valid_d = 1'b1;
            state_d = IDLE;
          end else if (final_pending_q) begin
            buf_d = {(padded_q ? 8'h00 : PAD_BYTE), {(BLOCK_W-LEN_W-8){1'b0}}, len_q};
            is_final_d = 1'b1;
            final_pending_d = 1'b0;
            state_d = SEND;
          end else begin
            buf_d = '0;
            idx_d = '0;
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      buf_q <= '0;
      padded_q <= 1'b0;
      final_pending_q <= 1'b0;
      is_final_q <= 1'b0;
      wait_first_q <= 1'b0;
      digest_q <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      buf_q <= buf_d;
      padded_q <= padded_d;
      final_pending_q <= final_pending_d;
      is_final_q <= is_final_d;
      wait_first_q <= wait_first_d;
      digest_q <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end
endmodule

// File: tb/tb_jh_padder.sv
// tb_jh_padder: table-driven and scoreboard checks of jh_padder against a reference padder and F8 stand-in
module tb_jh_padder;
  localparam int DB = 256;
  localparam logic [1023:0] IV = {32{32'h6a09e667}};
  typedef struct {
    int n;
    bit tail;
    int blocks;
  } vec_t;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [63:0]    s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_last = 1'b0;
  logic [3:0]     s_bytes = '0;
  logic           s_ready, f8_init, f8_enable, f8_done, digest_valid;
  logic [511:0]   f8_buffer;
  logic [1023:0]  f8_state_h;
  logic [DB-1:0]  digest;
  logic [1023:0]  st;
  int             cnt;
  logic           done_q;
  int             n_chk = 0, n_pass = 0;
  int             cyc = 0;
  int             n_en = 0, n_init = 0, n_dig = 0;
  int             last_en = -1;
  logic           busy = 1'b0, awaiting = 1'b0;
  logic [511:0]   cap;
  logic [511:0]   exp_blk[$];
  logic [DB-1:0]  exp_dig[$];
  logic [7:0]     msg[$];
  vec_t           vecs[9];
  always #5 clk = ~clk;
  jh_padder #(.DIGEST_BITS(DB)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_bytes(s_bytes), .s_ready(s_ready), .f8_init(f8_init), .f8_enable(f8_enable),
    .f8_buffer(f8_buffer), .f8_done(f8_done), .f8_state_h(f8_state_h),
    .digest(digest), .digest_valid(digest_valid)
  );
  function automatic logic [1023:0] mix(input logic [1023:0] s, input logic [511:0] b);
    return {s[1022:0], s[1023]} ^ {b, ~b};
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      st <= IV;
      cnt <= 0;
      done_q <= 1'b1;
    end else begin
      if (f8_init) st <= IV;
      else if (f8_enable) st <= mix(st, f8_buffer);
      if (f8_enable) cnt <= 35;
      else if (cnt != 0) cnt <= cnt - 1;
      done_q <= cnt == 0;
    end
  end
  assign f8_done = done_q;
  assign f8_state_h = st;
  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic fail(input string nm, input string got, input string req);
    n_chk++;
    $display("FAIL %s: got %s required %s", nm, got, req);
  endtask
  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy = 1'b0;
      awaiting = 1'b0;
      last_en = -1;
    end else begin
      if (f8_init) begin
        n_init++;
        chk("init_after_digest", awaiting, 1'b0);
        awaiting = 1'b1;
      end
      if (f8_enable) begin
        n_en++;
        if (last_en >= 0) chk("enable_gap_ge_37", (cyc - last_en) >= 37, 1'b1);
        last_en = cyc;
        if (exp_blk.size() == 0) fail("block", "unexpected enable", "no enable");
        else chk("block", f8_buffer, exp_blk.pop_front());
        cap = f8_buffer;
        busy = 1'b1;
      end else if (busy) begin
        chk("hold_while_busy", {s_ready, f8_buffer}, {1'b0, cap});
        if (cnt == 0 && f8_done) busy = 1'b0;
      end
      if (digest_valid) begin
        n_dig++;
        awaiting = 1'b0;
        if (exp_dig.size() == 0) fail("digest", "unexpected digest_valid", "no pulse");
        else chk("digest", digest, exp_dig.pop_front());
      end
    end
  end
  task automatic mk(input int n);
    logic [23:0] abc;
    abc = 24'h616263;
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(n == 3 ? abc[23-8*i -: 8] : 8'($urandom));
  endtask
  task automatic expect_msg(input logic [7:0] m[$]);
    int n;
    logic [511:0] b;
    logic [127:0] len;
    logic [1023:0] s;
    n = m.size();
    len = 128'(8 * n);
    s = IV;
    b = '0;
    for (int i = 0; i < n; i++) begin
      b[511-8*(i%64) -: 8] = m[i];
      if (i % 64 == 63) begin
        exp_blk.push_back(b);
        s = mix(s, b);
        b = '0;
      end
    end
    if (n % 64 != 0) begin
      b[511-8*(n%64) -: 8] = 8'h80;
      exp_blk.push_back(b);
      s = mix(s, b);
      b = {384'b0, len};
    end else b = {8'h80, 376'b0, len};
    exp_blk.push_back(b);
    s = mix(s, b);
    exp_dig.push_back(s[DB-1:0]);
  endtask
  task automatic drive_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int t;
    s_data = d;
    s_last = last;
    s_bytes = nb;
    s_valid = 1'b1;
    t = 0;
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) fail("s_ready_timeout", "s_ready low 2000 cycles", "word accepted");
    @(negedge clk);
  endtask
  task automatic send_msg(input logic [7:0] m[$], input bit tail);
    int n, nw, nb;
    logic [63:0] w;
    n = m.size();
    if (n == 0) drive_word(64'hdead_beef_cafe_f00d, 1'b1, 4'd0);
    else begin
      nw = (n + 7) / 8;
      for (int k = 0; k < nw; k++) begin
        nb = (k == nw - 1) ? n - 8 * k : 8;
        w = {$urandom, $urandom};
        for (int i = 0; i < nb; i++) w[63-8*i -: 8] = m[8*k+i];
        drive_word(w, (k == nw - 1) && !tail, 4'(nb));
      end
      if (tail) drive_word({$urandom, $urandom}, 1'b1, 4'd0);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask
  task automatic wait_dig(input int target);
    int t;
    t = 0;
    while (n_dig < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (n_dig < target) fail("digest_timeout", "no digest_valid in 3000 cycles", "digest_valid");
  endtask
  task automatic check_reset();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_f8_init", f8_init, 1'b0);
    chk("rst_f8_enable", f8_enable, 1'b0);
    chk("rst_f8_buffer", f8_buffer, '0);
    chk("rst_digest", digest, '0);
    chk("rst_digest_valid", digest_valid, 1'b0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 required finish");
    $fatal(1);
  end
  initial begin
    int e0, i0, d0, t;
    vecs[0] = '{0, 1'b0, 1};
    vecs[1] = '{3, 1'b0, 2};
    vecs[2] = '{64, 1'b0, 2};
    vecs[3] = '{72, 1'b0, 3};
    vecs[4] = '{55, 1'b0, 2};
    vecs[5] = '{8, 1'b1, 2};
    vecs[6] = '{64, 1'b1, 2};
    vecs[7] = '{127, 1'b0, 3};
    vecs[8] = '{130, 1'b0, 4};
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    for (int v = 0; v < 9; v++) begin
      mk(vecs[v].n);
      e0 = n_en;
      i0 = n_init;
      d0 = n_dig;
      expect_msg(msg);
      send_msg(msg, vecs[v].tail);
      wait_dig(d0 + 1);
      chk("block_count", n_en - e0, vecs[v].blocks);
      chk("init_count", n_init - i0, 1);
    end
    mk(3);
    expect_msg(msg);
    send_msg(msg, 1'b0);
    t = 0;
    while (!busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!busy) fail("busy_timeout", "no enable", "enable");
    repeat (5) @(negedge clk);
    exp_blk.delete();
    exp_dig.delete();
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {f8_init, s_ready}, 2'b00);
    mk(3);
    i0 = n_init;
    d0 = n_dig;
    expect_msg(msg);
    send_msg(msg, 1'b0);
    wait_dig(d0 + 1);
    chk("init_count_after_rst", n_init - i0, 1);
    i0 = n_init;
    d0 = n_dig;
    mk(20);
    expect_msg(msg);
    send_msg(msg, 1'b0);
    mk(70);
    expect_msg(msg);
    send_msg(msg, 1'b0);
    wait_dig(d0 + 2);
    chk("b2b_init_count", n_init - i0, 2);
    chk("b2b_queue_drained", exp_blk.size() + exp_dig.size(), 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
